// File: rtl/aes_key_sched.sv
// Iterative AES-128/192/256 key expander: one schedule word per clock, round keys
// served from an internal store. Optional `AES_KEYSCHED_ZEROIZE_EN adds a zeroize input.
module aes_key_sched #(
  parameter int unsigned MAX_NK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
`ifdef AES_KEYSCHED_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic [3:0]   rd_round,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         keys_valid,
  output logic [127:0] rd_key
);

  localparam int unsigned DEPTH  = 4 * (MAX_NK + 7);
  localparam int unsigned IW     = 6;
  localparam logic [3:0]  MAX_NR = 4'(MAX_NK + 6);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  i_q, i_d;
  logic [2:0]     j_q, j_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [3:0]     nk_q, nk_d;
  logic           busy_d, done_d, err_d, kv_d;
  logic           load, wr_en, clr;
  logic [3:0]     nk_req;
  logic           legal;
  logic [31:0]    store [DEPTH];

  logic [IW-1:0]  prev_idx, old_idx, w_last, rd_base;
  logic [31:0]    prev, sub_in, sub_out, temp, new_word;
  logic [3:0]     nr;
  logic           rd_ok;
  logic [127:0]   rd_data;

`ifdef AES_KEYSCHED_ZEROIZE_EN
  assign clr = zeroize;
`else
  assign clr = 1'b0;
`endif

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (b^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq, inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) inv = gmul(inv, sq);
      sq = gmul(sq, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Single four-byte S-box slice shared by the RotWord and Nk=8 paths
  always_comb begin
    prev_idx = i_q - IW'(1);
    old_idx  = i_q - IW'(nk_q);
    prev     = store[prev_idx];
    sub_in   = (j_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    if (j_q == 3'd0)
      temp = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && j_q == 3'd4)
      temp = sub_out;
    else
      temp = prev;
    new_word = store[old_idx] ^ temp;
    w_last   = {nk_q, 2'b00} + IW'(27);
  end

  always_comb begin
    case (key_len)
      2'd0:    nk_req = 4'd4;
      2'd1:    nk_req = 4'd6;
      default: nk_req = 4'd8;
    endcase
    legal = (key_len != 2'd3) && (nk_req <= 4'(MAX_NK));
  end

  // Next-state and control
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    rcon_d  = rcon_q;
    nk_d    = nk_q;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = 1'b0;
    kv_d    = keys_valid;
    load    = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal) begin
            load    = 1'b1;
            nk_d    = nk_req;
            i_d     = IW'(nk_req);
            j_d     = 3'd0;
            rcon_d  = 8'h01;
            busy_d  = 1'b1;
            kv_d    = 1'b0;
            state_d = EXPAND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EXPAND: begin
        wr_en = 1'b1;
        i_d   = i_q + IW'(1);
        j_d   = (j_q == 3'(nk_q - 4'd1)) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0)
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (i_q == w_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      kv_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      load    = 1'b0;
      wr_en   = 1'b0;
    end
  end

  always_comb begin
    nr      = nk_q + 4'd6;
    rd_ok   = (rd_round <= nr) && (rd_round <= MAX_NR);
    rd_base = rd_ok ? {rd_round, 2'b00} : '0;
    rd_data = rd_ok ? {store[rd_base], store[rd_base + IW'(1)],
                       store[rd_base + IW'(2)], store[rd_base + IW'(3)]} : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= IW'(4);
      j_q        <= 3'd0;
      rcon_q     <= 8'h01;
      nk_q       <= 4'd4;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      keys_valid <= 1'b0;
      rd_key     <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      rcon_q     <= rcon_d;
      nk_q       <= nk_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      keys_valid <= kv_d;
      rd_key     <= clr ? '0 : rd_data;
    end
  end

  // Round-key store: key words land in one cycle, then one derived word per cycle
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < int'(DEPTH); k++) store[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < 8; k++)
        if (4'(k) < nk_req) store[IW'(k)] <= key[255 - 32*k -: 32];
    end else if (wr_en) begin
      store[i_q] <= new_word;
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Scoreboard bench for aes_key_sched: FIPS-197 reference expansion, event and read queues.
module tb_aes_key_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, start = 1'b0, start4 = 1'b0;
  logic [1:0]   key_len = '0, key_len4 = '0;
  logic [255:0] key = '0;
  logic [3:0]   rd_round = '0;
  logic         busy, done, err, keys_valid, busy4, done4, err4, kv4;
  logic [127:0] rd_key, rd_key4;
`ifdef AES_KEYSCHED_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  aes_key_sched #(.MAX_NK(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
`ifdef AES_KEYSCHED_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .rd_round(rd_round), .busy(busy), .done(done), .err(err),
    .keys_valid(keys_valid), .rd_key(rd_key));

  aes_key_sched #(.MAX_NK(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .key_len(key_len4), .key(key),
`ifdef AES_KEYSCHED_ZEROIZE_EN
    .zeroize(1'b0),
`endif
    .rd_round(rd_round), .busy(busy4), .done(done4), .err(err4),
    .keys_valid(kv4), .rd_key(rd_key4));

  typedef struct { int kind; int when; } evt_t;   // kind 1 = done, 2 = err
  evt_t         evq[$];
  evt_t         mon_e;
  int           mon_kind;
  logic [127:0] rdq[$];
  logic         rd_req = 1'b0, rd_req_d = 1'b0;
  int           cyc = 0;
  int           n_chk = 0, n_pass = 0;

  logic [7:0]   sbox_t[256];
  logic [31:0]  mw[60];
  int           m_nk = 4;
  bit           m_ok = 0;
  int           done_cyc = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_req_d <= rd_req;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, 128'(act), 128'(exp));
  endtask

  // Monitor: pops expected events and read data whenever the DUT presents them
  always @(negedge clk) begin
    if (rd_req_d && rdq.size() != 0) check("rd_key", rd_key, rdq.pop_front());
    if (done || err) begin
      mon_kind = done ? 1 : 2;
      chk1("done_err_excl", done & err, 1'b0);
      if (evq.size() == 0) check("unexpected_evt", 128'(mon_kind), 128'(0));
      else begin
        mon_e = evq.pop_front();
        check("evt_kind", 128'(mon_kind), 128'(mon_e.kind));
        check("evt_cycle", 128'(cyc), 128'(mon_e.when));
      end
    end
  end

  // S-box from log/antilog tables over generator 0x03 and the bitwise affine rule
  task automatic build_sbox();
    logic [7:0] ex[256];
    int         lg[256];
    logic [7:0] e, inv, s, c;
    c = 8'h63;
    e = 8'h01;
    for (int k = 0; k < 255; k++) begin
      ex[k] = e;
      lg[e] = k;
      e = e ^ ({e[6:0], 1'b0} ^ (e[7] ? 8'h1b : 8'h00));
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  task automatic model_expand(input int nk, input logic [255:0] k);
    logic [7:0]  rc[11];
    logic [31:0] t;
    rc[1] = 8'h01;
    for (int n = 2; n < 11; n++)
      rc[n] = {rc[n-1][6:0], 1'b0} ^ (rc[n-1][7] ? 8'h1b : 8'h00);
    for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 60; i++) mw[i] = '0;
    m_ok = 0;
    done_cyc = cyc;
  endtask

  function automatic logic [127:0] exp_round(input int r);
    if (r > m_nk + 6 || r > 14) return '0;
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Issue a start; the model decides accept / reject / ignore and queues the expected event
  task automatic do_start(input logic [1:0] len, input logic [255:0] k);
    int nk;
    nk = (len == 2'd0) ? 4 : (len == 2'd1) ? 6 : 8;
    start = 1'b1; key_len = len; key = k;
    if (cyc >= done_cyc) begin
      if (len == 2'd3) evq.push_back('{2, cyc + 1});
      else begin
        model_expand(nk, k);
        m_nk = nk;
        m_ok = 1;
        done_cyc = cyc + 1 + 4*(nk+7) - nk;
        evq.push_back('{1, done_cyc});
      end
    end
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_read(input int r, input logic [127:0] exp);
    rd_round = 4'(r);
    rd_req = 1'b1;
    rdq.push_back(exp);
    tick(1);
    rd_req = 1'b0;
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
    return k;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_kv"}, keys_valid, 1'b0);
    check({tag, "_rd_key"}, rd_key, '0);
  endtask

  initial begin
    logic [255:0] k;
    logic [1:0]   len;
    int           c0;
    build_sbox();
    for (int i = 0; i < 60; i++) mw[i] = '0;

    tick(3);
    check_idle_outputs("reset");
    chk1("reset_done", done, 1'b0);
    chk1("reset_err", err, 1'b0);
    rst = 1'b0;
    tick(1);
    do_read(0, exp_round(0));

    // AES-128 known answer
    do_start(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
    chk1("busy_128", busy, 1'b1);
    wait_until(done_cyc);
    chk1("kv_128", keys_valid, 1'b1);
    tick(1);
    do_read(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    do_read(0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    do_read(11, 128'h0);
    do_read(5, exp_round(5));

    // AES-192 known answer
    do_start(2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
    wait_until(done_cyc);
    tick(1);
    do_read(12, 128'he98ba06f448c773c8ecc720401002202);
    do_read(13, 128'h0);

    // AES-256 known answer, with an ignored start while busy
    do_start(2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    tick(8);
    do_start(2'd0, rand_key());
    do_start(2'd3, rand_key());
    wait_until(done_cyc);
    tick(1);
    do_read(14, 128'hfe4890d1e6188d0b046df344706c631e);
    do_read(15, 128'h0);

    // Illegal key_len rejected; schedule and keys_valid untouched
    do_start(2'd3, rand_key());
    tick(1);
    chk1("kv_after_err", keys_valid, 1'b1);
    do_read(14, 128'hfe4890d1e6188d0b046df344706c631e);

    // MAX_NK=4 instance rejects AES-256, accepts AES-128
    start4 = 1'b1; key_len4 = 2'd2;
    tick(1);
    start4 = 1'b0;
    chk1("nk4_err", err4, 1'b1);
    chk1("nk4_busy", busy4, 1'b0);
    start4 = 1'b1; key_len4 = 2'd0;
    tick(1);
    start4 = 1'b0;
    chk1("nk4_accept_busy", busy4, 1'b1);
    chk1("nk4_accept_err", err4, 1'b0);

    // Reset 20 cycles into an AES-256 expansion
    do_start(2'd2, rand_key());
    tick(19);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    void'(evq.pop_back());
    model_clear();
    m_nk = 4;
    check_idle_outputs("midrst");
    for (int r = 0; r <= 10; r++) do_read(r, exp_round(r));
    tick(40);

    // Back-to-back AES-128 starts in the done cycle
    do_start(2'd0, rand_key());
    wait_until(done_cyc);
    c0 = cyc;
    do_start(2'd0, rand_key());
    check(("b2b_gap"), 128'(done_cyc - c0), 128'(41));
    wait_until(done_cyc);
    tick(1);
    do_read(10, exp_round(10));

    // Randomised keys and lengths against the reference model
    for (int n = 0; n < 12; n++) begin
      len = 2'($urandom_range(0, 3));
      k = rand_key();
      do_start(len, k);
      if ($urandom_range(0, 1) == 1) begin
        tick(int'($urandom_range(1, 30)));
        do_start(2'($urandom_range(0, 3)), rand_key());
      end
      wait_until(done_cyc);
      tick(1);
      chk1("rand_kv", keys_valid, m_ok);
      for (int r = 0; r < 3; r++) begin
        c0 = int'($urandom_range(0, 15));
        do_read(c0, exp_round(c0));
      end
      do_read(m_nk + 6, exp_round(m_nk + 6));
    end

`ifdef AES_KEYSCHED_ZEROIZE_EN
    // Zeroize mid-expansion, then zeroize together with start
    do_start(2'd2, rand_key());
    tick(15);
    zeroize = 1'b1;
    tick(1);
    zeroize = 1'b0;
    void'(evq.pop_back());
    model_clear();
    check_idle_outputs("zeroize");
    for (int r = 0; r <= 15; r++) do_read(r, 128'h0);
    zeroize = 1'b1; start = 1'b1; key_len = 2'd0;
    tick(1);
    zeroize = 1'b0; start = 1'b0;
    chk1("zero_start_busy", busy, 1'b0);
    tick(45);
`endif

    tick(3);
    check("evq_drained", 128'(evq.size()), 128'(0));
    check("rdq_drained", 128'(rdq.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

Iterative, parametrised AES key-expansion engine supporting AES-128/192/256. It accepts a cipher key with a start pulse and generates one 32-bit schedule word per clock using a single 4-byte S-box slice. All 4·(Nr+1) words are held in an internal round-key store, and round keys are served through a registered read port. It replaces the fully unrolled 128-bit combinational expander in the cipher datapath.

## Interface
- `MAX_NK`, default 8: largest supported key length in words. Legal values are 4, 6 and 8. Store depth is 4·(MAX_NK+7) words.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to expand `key`.
- `key_len`  in  2: 0 = AES-128 (Nk=4), 1 = AES-192 (Nk=6), 2 = AES-256 (Nk=8), 3 = illegal.
- `key`  in  256: cipher key, MSB-aligned. w[0] = key[255:224]. Unused LSBs are ignored.
- `busy`  out  1: expansion in progress.
- `done`  out  1: one-cycle pulse when expansion completes.
- `err`  out  1: one-cycle pulse when a start is rejected.
- `keys_valid`  out  1: the store holds a complete schedule.
- `rd_round`  in  4: round-key index 0..Nr.
- `rd_key`  out  128: round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.

## Operation
**Derived values**
- Nr = Nk + 6.
- Total words W = 44 / 52 / 60.

**States**
- IDLE → EXPAND on an accepted start.
- EXPAND → IDLE after the last word is written.

**Start acceptance**
- A start is accepted only in IDLE, with `key_len` ≤ 2 and Nk ≤ MAX_NK.
- Otherwise: in IDLE, `err` pulses and the store is unchanged. In EXPAND, the start is ignored with no `err`.

**On accept**
- w[0..Nk-1] are written in one cycle.
- `keys_valid` is cleared.
- Index i is set to Nk, phase counter j to 0, and rcon to 0x01.

**Each EXPAND cycle**
- temp = w[i-1].
- If j == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon), i.e. 01,02,04,…,80,1b,36.
- Else if Nk == 8 and j == 4: temp = SubWord(temp).
- w[i] = w[i-Nk] ^ temp.
- i increments; j wraps modulo Nk. Division/modulo hardware is not used.

**Completion**
- After w[W-1] is written: return to IDLE, pulse `done`, set `keys_valid`.

**Read port**
- `rd_key` is registered from `rd_round`, independent of state.
- `rd_round` > Nr of the last accepted key, or > MAX_NK+6, returns 0.
- During EXPAND, reads return current store contents. Words not yet rewritten hold their previous values, and only `keys_valid` qualifies them.

## Timing
**Reset**
- All outputs are 0 (`busy`, `done`, `err`, `keys_valid`, `rd_key`).
- The store is zeroed, state is IDLE, and Nk is recorded as 4.

**Expansion timing**
- Start sampled at edge T: `busy` = 1 from T, initial words are stored at T.
- w[Nk+k] is written at edge T+1+k.
- The last word is written at edge T+W-Nk, i.e. T+40 / T+46 / T+52.
- At that edge: `busy` → 0, `done` → 1 for one cycle, `keys_valid` → 1.
- Start-to-done latency is therefore 40 / 46 / 52 cycles.

**Boundary cases**
- A new start is accepted in the cycle `done` is high (back-to-back operation).
- Read latency is 1 cycle. A read of a word written at edge E, sampled at edge E+1, returns the new value.
- `rst` asserted mid-expansion aborts on that edge with full reset values. No `done` is issued.
- `err` and `done` are never asserted in the same cycle.

## Configuration
- **`AES_KEYSCHED_ZEROIZE_EN` defined:**
  - Adds input port `zeroize` (1 bit).
  - When high at an edge, it zeroes the store, clears `keys_valid`, `busy` and `rd_key`, and returns to IDLE with no `done`.
  - It has priority over `start`; a start in the same cycle is dropped without `err`.
- **Not defined:** the port is absent and the store is cleared only by `rst` or overwritten by a new expansion.

## Test plan
- AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c → `done` 40 cycles after start; `rd_round`=10 gives d014f9a8 c9ee2589 e13f0cc8 b6630ca6; `rd_round`=0 returns the key; `rd_round`=11 returns 0.
- AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b → `done` after 46 cycles; `rd_round`=12 gives e98ba06f 448c773c 8ecc7204 01002202.
- AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 → `done` after 52 cycles; `rd_round`=14 gives fe4890d1 e6188d0b 046df344 706c631e.
- Rejects:
  - `key_len`=3 → `err` pulse, `keys_valid` unchanged.
  - MAX_NK=4 with `key_len`=2 → `err`.
  - Start during `busy` → ignored, `done` still at the original cycle.
- `rst` at cycle 20 of AES-256 → all outputs 0, store reads 0, no `done`. A back-to-back start in the `done` cycle → second `done` exactly 40 cycles later for AES-128.
- With `AES_KEYSCHED_ZEROIZE_EN`: `zeroize` mid-expansion → `busy`=0, `keys_valid`=0, all rounds read 0. `zeroize` and `start` together → no expansion, no `err`.
